// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority search over 8 requests starting at ptr, optionally
// skipping one index (used to force a hold-limit rotation).
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_found
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!pick_found && req[idx] && !(excl_en && idx == excl_idx)) begin
                pick_idx   = idx;
                pick_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and a
// hold-limit counter that forces rotation when others are waiting.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    // HOLD_MAX == 0 means unlimited; the counter then just saturates at all-ones.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (HOLD_MAX == 0) ? '1 : HOLD_W'(HOLD_MAX - 1);
    localparam bit HOLD_LIMITED = (HOLD_MAX != 0);

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              load;
    logic              drop;

    rr_pick8 u_pick (
        .req        (req),
        .ptr        (ptr),
        .excl_en    (state == GRANT),
        .excl_idx   (gnt_idx),
        .pick_idx   (pick_idx),
        .pick_found (pick_found)
    );

    // In GRANT the picker excludes the holder, so pick_found means "another request pending".
    always_comb begin
        load = 1'b0;
        drop = 1'b0;
        case (state)
            IDLE: load = pick_found;
            GRANT: begin
                if (!req[gnt_idx]) begin
                    load = pick_found;
                    drop = !pick_found;
                end else if (HOLD_LIMITED && hold_cnt == HOLD_LAST && pick_found) begin
                    load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (load) begin
            state     <= GRANT;
            ptr       <= pick_idx + IDX_W'(1);
            hold_cnt  <= '0;
            gnt       <= N_REQ'(1) << pick_idx;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
        end else if (drop) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
            hold_cnt  <= hold_cnt + HOLD_W'(1);
        end
    end

endmodule
